// File: rtl/banked_regfile.sv
// banked_regfile: register file with per-bank r[BANKED_LO..14], exception entry/return FSM and bank stack.
// Optional REGFILE_BYPASS_EN forwards same-cycle write data to reads.
module banked_regfile #(
    parameter int DATA_W = 32,
    parameter int NUM_BANKS = 4,
    parameter int NUM_RD = 4,
    parameter int BANKED_LO = 13,
    parameter int NEST_D = 4,
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [4*NUM_RD-1:0]      i_rd_code,
    output logic [DATA_W*NUM_RD-1:0] o_rd_reg,
    input  logic [DATA_W-1:0]        i_pc_next,
    input  logic                     i_we_ex,
    input  logic [3:0]               i_wcode_ex,
    input  logic [DATA_W-1:0]        i_wdata_ex,
    input  logic                     i_we_wb,
    input  logic [3:0]               i_wcode_wb,
    input  logic [DATA_W-1:0]        i_wdata_wb,
    output logic                     o_pc_en,
    output logic [DATA_W-1:0]        o_pc_reg,
    input  logic                     i_exc_req,
    input  logic [BANK_W-1:0]        i_exc_bank,
    input  logic [DATA_W-1:0]        i_exc_ret,
    output logic                     o_exc_ack,
    input  logic                     i_ret_req,
    output logic                     o_ret_ack,
    output logic [DATA_W-1:0]        o_ret_pc,
    output logic [BANK_W-1:0]        o_bank,
    output logic                     o_busy,
    output logic                     o_nest_full
);
    localparam int SP_W = $clog2(NEST_D + 1);
    localparam logic [3:0] LO = 4'(BANKED_LO);
    localparam logic [3:0] R14 = 4'd14;
    localparam logic [3:0] PC = 4'd15;
    typedef enum logic [1:0] {IDLE, ENTER, RETURN} state_t;
    state_t state, state_n;
    // Arrays span all 16 codes; entries outside their range are never written and stay constant.
    logic [DATA_W-1:0] shr [16];
    logic [DATA_W-1:0] bnk [1<<BANK_W][16];
    logic [BANK_W-1:0] stk [1<<SP_W];
    logic [SP_W-1:0]   sp;
    logic [BANK_W-1:0] bank, lat_bank;
    logic [DATA_W-1:0] lat_ret, rd_v;
    logic [3:0]        rd_c;
    logic              full, take_exc, take_ret;
    assign full = sp == SP_W'(NEST_D);
    assign take_exc = state == IDLE && i_exc_req && !full;
    assign take_ret = state == IDLE && !i_exc_req && i_ret_req && sp != '0;
    always_comb begin
        state_n = take_exc ? ENTER : take_ret ? RETURN : IDLE;
    end
    always_comb begin
        o_rd_reg = '0;
        rd_c = '0;
        rd_v = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_c = i_rd_code[4*k +: 4];
            rd_v = rd_c == PC ? i_pc_next : rd_c < LO ? shr[rd_c] : bnk[bank][rd_c];
`ifdef REGFILE_BYPASS_EN
            if (en && rd_c != PC)
                rd_v = (i_we_ex && i_wcode_ex == rd_c) ? i_wdata_ex :
                       (i_we_wb && i_wcode_wb == rd_c) ? i_wdata_wb : rd_v;
`endif
            o_rd_reg[DATA_W*k +: DATA_W] = rd_v;
        end
    end
    assign o_pc_en = (i_we_ex && i_wcode_ex == PC) || (i_we_wb && i_wcode_wb == PC);
    assign o_pc_reg = (i_we_wb && i_wcode_wb == PC) ? i_wdata_wb : i_wdata_ex;
    assign o_exc_ack = !rst && en && state == ENTER;
    assign o_ret_ack = !rst && en && state == RETURN;
    assign o_ret_pc = bnk[bank][R14];
    assign o_bank = bank;
    assign o_busy = !rst && state != IDLE;
    assign o_nest_full = !rst && full;
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) shr[i] <= '0;
            for (int b = 0; b < (1<<BANK_W); b++)
                for (int i = 0; i < 16; i++) bnk[b][i] <= '0;
            for (int i = 0; i < (1<<SP_W); i++) stk[i] <= '0;
            sp <= '0;
            bank <= '0;
            lat_bank <= '0;
            lat_ret <= '0;
            state <= IDLE;
        end else if (en) begin
            // WB first so a colliding EX write lands last and wins.
            if (i_we_wb && i_wcode_wb != PC) begin
                if (i_wcode_wb < LO) shr[i_wcode_wb] <= i_wdata_wb;
                else bnk[bank][i_wcode_wb] <= i_wdata_wb;
            end
            if (i_we_ex && i_wcode_ex != PC) begin
                if (i_wcode_ex < LO) shr[i_wcode_ex] <= i_wdata_ex;
                else bnk[bank][i_wcode_ex] <= i_wdata_ex;
            end
            if (state == ENTER) begin
                bnk[lat_bank][R14] <= lat_ret;
                stk[sp] <= bank;
                sp <= sp + 1'b1;
                bank <= lat_bank;
            end
            if (state == RETURN) begin
                sp <= sp - 1'b1;
                bank <= stk[sp - 1'b1];
            end
            if (take_exc) begin
                lat_bank <= i_exc_bank;
                lat_ret <= i_exc_ret;
            end
            state <= state_n;
        end
    end
endmodule

// File: tb/tb_banked_regfile.sv
// tb_banked_regfile: vector table, directed exception sequences and randomized run against a queue-based model.
module tb_banked_regfile;
    logic        clk = 1'b0;
    logic        rst, en;
    logic [15:0] rd_code;
    logic [127:0] rd_reg;
    logic [31:0] pc_next;
    logic        we_ex, we_wb;
    logic [3:0]  wc_ex, wc_wb;
    logic [31:0] wd_ex, wd_wb;
    logic        pc_en;
    logic [31:0] pc_reg;
    logic        exc_req, ret_req, exc_ack, ret_ack, busy, nest_full;
    logic [1:0]  exc_bank, bank;
    logic [31:0] exc_ret, ret_pc;
    int total = 0, bad = 0;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    banked_regfile dut (
        .clk(clk), .rst(rst), .en(en), .i_rd_code(rd_code), .o_rd_reg(rd_reg), .i_pc_next(pc_next),
        .i_we_ex(we_ex), .i_wcode_ex(wc_ex), .i_wdata_ex(wd_ex),
        .i_we_wb(we_wb), .i_wcode_wb(wc_wb), .i_wdata_wb(wd_wb),
        .o_pc_en(pc_en), .o_pc_reg(pc_reg),
        .i_exc_req(exc_req), .i_exc_bank(exc_bank), .i_exc_ret(exc_ret), .o_exc_ack(exc_ack),
        .i_ret_req(ret_req), .o_ret_ack(ret_ack), .o_ret_pc(ret_pc),
        .o_bank(bank), .o_busy(busy), .o_nest_full(nest_full)
    );
    always #5 clk = ~clk;
    // Reference model: shared/banked arrays, a queue for the bank stack, pending-operation tag.
    logic [31:0] sh_m [16];
    logic [31:0] bk_m [4][16];
    logic [1:0]  stk_m [$];
    logic [1:0]  bank_m = 2'd0, tb_m = 2'd0;
    logic [31:0] tret_m = '0;
    int          op_m = 0;
    function automatic void m_wr(input logic [3:0] c, input logic [31:0] d);
        if (c < 4'd13) sh_m[c] = d;
        else bk_m[bank_m][c] = d;
    endfunction
    function automatic logic [31:0] m_read(input logic [3:0] c);
        if (c == 4'd15) return pc_next;
        if (BYP && en && we_ex && wc_ex == c) return wd_ex;
        if (BYP && en && we_wb && wc_wb == c) return wd_wb;
        return c < 4'd13 ? sh_m[c] : bk_m[bank_m][c];
    endfunction
    function automatic void m_step();
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                sh_m[i] = '0;
                for (int b = 0; b < 4; b++) bk_m[b][i] = '0;
            end
            stk_m.delete();
            bank_m = '0;
            op_m = 0;
        end else if (en) begin
            if (we_wb && wc_wb != 4'd15) m_wr(wc_wb, wd_wb);
            if (we_ex && wc_ex != 4'd15) m_wr(wc_ex, wd_ex);
            if (op_m == 1) begin
                bk_m[tb_m][14] = tret_m;
                stk_m.push_back(bank_m);
                bank_m = tb_m;
                op_m = 0;
            end else if (op_m == 2) begin
                bank_m = stk_m.pop_back();
                op_m = 0;
            end else if (exc_req && stk_m.size() < 4) begin
                tb_m = exc_bank;
                tret_m = exc_ret;
                op_m = 1;
            end else if (!exc_req && ret_req && stk_m.size() > 0) begin
                op_m = 2;
            end
        end
    endfunction
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", n, a, e);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
    endtask
    task automatic idle_in();
        we_ex = 0; wc_ex = 0; wd_ex = 0; we_wb = 0; wc_wb = 0; wd_wb = 0;
        exc_req = 0; exc_bank = 0; exc_ret = 0; ret_req = 0; rd_code = 0;
    endtask
    task automatic rd0(input logic [3:0] c, input logic [31:0] e, input string n);
        rd_code = {12'h0, c};
        #1;
        chk(n, rd_reg[31:0], e);
    endtask
    typedef struct {
        logic we_ex; logic [3:0] wc_ex; logic [31:0] wd_ex;
        logic we_wb; logic [3:0] wc_wb; logic [31:0] wd_wb;
        logic [3:0] rc; logic [31:0] exp_st; logic [31:0] exp_by;
        logic pc_en; logic [31:0] pc_reg;
    } vec_t;
    vec_t vt [11];
    logic [1:0]  nb [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [31:0] npc [4] = '{32'h3003, 32'h3002, 32'h3001, 32'h3000};
    logic [1:0]  nbk [4] = '{2'd3, 2'd2, 2'd1, 2'd0};
    initial begin
        vt[0]  = '{0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0};
        vt[1]  = '{0, 0, 0, 0, 0, 0, 4'd15, 32'h100, 32'h100, 0, 0};
        vt[2]  = '{1, 3, 32'hAAAA, 1, 3, 32'h5555, 4'd3, 0, 32'hAAAA, 0, 32'hAAAA};
        vt[3]  = '{0, 0, 0, 0, 0, 0, 4'd3, 32'hAAAA, 32'hAAAA, 0, 0};
        vt[4]  = '{1, 15, 32'h40, 1, 15, 32'h80, 4'd3, 32'hAAAA, 32'hAAAA, 1, 32'h80};
        vt[5]  = '{1, 15, 32'h40, 0, 0, 0, 4'd3, 32'hAAAA, 32'hAAAA, 1, 32'h40};
        vt[6]  = '{0, 0, 0, 1, 15, 32'h80, 4'd3, 32'hAAAA, 32'hAAAA, 1, 32'h80};
        vt[7]  = '{1, 5, 32'h77, 0, 0, 0, 4'd5, 0, 32'h77, 0, 32'h77};
        vt[8]  = '{0, 0, 0, 0, 0, 0, 4'd5, 32'h77, 32'h77, 0, 0};
        vt[9]  = '{0, 0, 0, 1, 13, 32'h11, 4'd13, 0, 32'h11, 0, 0};
        vt[10] = '{0, 0, 0, 0, 0, 0, 4'd13, 32'h11, 32'h11, 0, 0};
        idle_in();
        pc_next = 32'h100;
        rst = 1; en = 1;
        tick();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_full", nest_full, 0);
        chk("rst_exc_ack", exc_ack, 0);
        chk("rst_ret_ack", ret_ack, 0);
        rst = 0;
        tick();
        for (int g = 0; g < 4; g++) begin
            for (int k = 0; k < 4; k++) rd_code[4*k +: 4] = 4'(4*g + k);
            #1;
            for (int k = 0; k < 4; k++)
                chk($sformatf("rst_rd%0d", 4*g + k), rd_reg[32*k +: 32], (4*g + k == 15) ? 32'h100 : 32'h0);
        end
        chk("rst_bank", bank, 0);
        for (int i = 0; i < 11; i++) begin
            we_ex = vt[i].we_ex; wc_ex = vt[i].wc_ex; wd_ex = vt[i].wd_ex;
            we_wb = vt[i].we_wb; wc_wb = vt[i].wc_wb; wd_wb = vt[i].wd_wb;
            rd_code = {12'h0, vt[i].rc};
            #1;
            chk($sformatf("vec%0d_rd", i), rd_reg[31:0], BYP ? vt[i].exp_by : vt[i].exp_st);
            chk($sformatf("vec%0d_pc_en", i), pc_en, vt[i].pc_en);
            chk($sformatf("vec%0d_pc_reg", i), pc_reg, vt[i].pc_reg);
            tick();
        end
        idle_in();
        we_ex = 1; wc_ex = 13; wd_ex = 32'h11;
        tick();
        idle_in();
        exc_req = 1; exc_bank = 2; exc_ret = 32'h2000;
        tick();
        exc_req = 0;
        #1;
        chk("ent_ack", exc_ack, 1);
        chk("ent_bank_pre", bank, 0);
        chk("ent_busy", busy, 1);
        tick();
        chk("ent_ack_done", exc_ack, 0);
        chk("ent_bank", bank, 2);
        rd0(14, 32'h2000, "ent_r14");
        rd0(13, 32'h0, "ent_r13");
        ret_req = 1;
        tick();
        ret_req = 0;
        #1;
        chk("ret_ack", ret_ack, 1);
        chk("ret_pc", ret_pc, 32'h2000);
        tick();
        chk("ret_bank", bank, 0);
        rd0(13, 32'h11, "ret_r13");
        for (int i = 0; i < 4; i++) begin
            exc_req = 1; exc_bank = nb[i]; exc_ret = 32'h3000 + i;
            tick();
            exc_req = 0;
            #1;
            chk($sformatf("nest%0d_ack", i), exc_ack, 1);
            tick();
            chk($sformatf("nest%0d_bank", i), bank, nb[i]);
        end
        chk("nest_full", nest_full, 1);
        exc_req = 1; exc_bank = 1; exc_ret = 32'h4000;
        tick();
        exc_req = 0;
        #1;
        chk("full_no_ack", exc_ack, 0);
        chk("full_no_busy", busy, 0);
        tick();
        chk("full_bank", bank, 0);
        for (int i = 0; i < 5; i++) begin
            ret_req = 1;
            tick();
            ret_req = 0;
            #1;
            chk($sformatf("pop%0d_ack", i), ret_ack, i < 4);
            if (i < 4) chk($sformatf("pop%0d_pc", i), ret_pc, npc[i]);
            tick();
            chk($sformatf("pop%0d_bank", i), bank, i < 4 ? nbk[i] : 2'd0);
        end
        chk("pop_full", nest_full, 0);
        exc_req = 1; exc_bank = 1; exc_ret = 32'h5000;
        tick();
        exc_req = 0;
        tick();
        exc_req = 1; exc_bank = 2; exc_ret = 32'h6000; ret_req = 1;
        tick();
        exc_req = 0; ret_req = 0; en = 0;
        #1;
        chk("both_busy", busy, 1);
        chk("both_hold_ack", exc_ack, 0);
        chk("both_hold_ret", ret_ack, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("hold%0d_ack", i), exc_ack, 0);
            chk($sformatf("hold%0d_bank", i), bank, 1);
        end
        en = 1;
        #1;
        chk("both_ack", exc_ack, 1);
        chk("both_no_ret", ret_ack, 0);
        tick();
        chk("both_bank", bank, 2);
        rd0(14, 32'h6000, "both_r14");
        exc_req = 1; exc_bank = 3; exc_ret = 32'h7000;
        tick();
        exc_req = 0; rst = 1;
        #1;
        chk("abort_ack", exc_ack, 0);
        chk("abort_busy", busy, 0);
        tick();
        rst = 0;
        #1;
        chk("abort_bank", bank, 0);
        chk("abort_full", nest_full, 0);
        rd0(14, 32'h0, "abort_r14");
        rd0(3, 32'h0, "abort_r3");
        ret_req = 1;
        tick();
        ret_req = 0;
        #1;
        chk("empty_ret_busy", busy, 0);
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            en = ($urandom_range(0, 7) != 0);
            rd_code = 16'($urandom);
            pc_next = $urandom;
            we_ex = $urandom_range(0, 1); wc_ex = 4'($urandom); wd_ex = $urandom;
            we_wb = $urandom_range(0, 1); wc_wb = ($urandom_range(0, 3) == 0) ? wc_ex : 4'($urandom);
            wd_wb = $urandom;
            exc_req = ($urandom_range(0, 4) == 0); exc_bank = 2'($urandom); exc_ret = $urandom;
            ret_req = ($urandom_range(0, 6) == 0);
            #1;
            for (int k = 0; k < 4; k++) chk($sformatf("rnd_rd%0d", k), rd_reg[32*k +: 32], m_read(rd_code[4*k +: 4]));
            chk("rnd_pc_en", pc_en, (we_ex && wc_ex == 15) || (we_wb && wc_wb == 15));
            chk("rnd_pc_reg", pc_reg, (we_wb && wc_wb == 15) ? wd_wb : wd_ex);
            chk("rnd_exc_ack", exc_ack, !rst && en && op_m == 1);
            chk("rnd_ret_ack", ret_ack, !rst && en && op_m == 2);
            if (!rst && en && op_m == 2) chk("rnd_ret_pc", ret_pc, bk_m[bank_m][14]);
            chk("rnd_bank", bank, bank_m);
            chk("rnd_busy", busy, !rst && op_m != 0);
            chk("rnd_full", nest_full, !rst && stk_m.size() == 4);
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
